// File: rtl/neuron_pkg.sv
// Shared constants and helpers for the spike-to-AER path.
// - N_NEURONS / ADDR_W : spike vector width and matching neuron address width
// - TS_W               : timestep stamp width
// - FIFO_DEPTH         : AER FIFO entries (power of 2, >= 2)
// - AER_W / DROP_W     : packed AER word width and drop counter width
// - pack_aer()         : builds an AER word as {addr, ts}
package neuron_pkg;

    localparam int unsigned N_NEURONS  = 8;
    localparam int unsigned ADDR_W     = $clog2(N_NEURONS);
    localparam int unsigned TS_W       = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned AER_W      = ADDR_W + TS_W;
    localparam int unsigned DROP_W     = 8;

    function automatic logic [AER_W-1:0] pack_aer(input logic [ADDR_W-1:0] addr,
                                                  input logic [TS_W-1:0]   ts);
        return {addr, ts};
    endfunction

endpackage

// File: rtl/spike_aer_encoder_if.sv
// AER output stream (valid/ready) between the encoder and the pin driver.
// - aer_valid : head event present (driven by master)
// - aer_ready : consumer accepts the head (driven by slave)
// - aer_addr  : neuron index of the head event
// - aer_ts    : timestep stamp of the head event
interface spike_aer_encoder_if;
    import neuron_pkg::*;

    logic              aer_valid;
    logic              aer_ready;
    logic [ADDR_W-1:0] aer_addr;
    logic [TS_W-1:0]   aer_ts;

    modport master (output aer_valid, output aer_addr, output aer_ts, input aer_ready);
    modport slave  (input aer_valid, input aer_addr, input aer_ts, output aer_ready);

endinterface

// File: rtl/aer_fifo.sv
// Synchronous FIFO holding packed AER words.
// - clk, reset : rising-edge clock, synchronous active-high reset
// - push       : write push_data (accepted when not full, or when a pop frees a slot)
// - pop        : remove head (ignored when empty)
// - full/empty : occupancy flags
// - head       : data at the read pointer (undefined content when empty)
module aer_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [IDX_W:0]   wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Converts per-timestep spike vectors into a stream of AER events {addr, ts}.
// - clk, reset   : rising-edge clock, synchronous active-high reset
// - spikes_in    : spike vector of the current timestep
// - spikes_valid : one-cycle strobe marking the end of a timestep
// - aer          : AER output stream (master side)
// - busy         : events still pending or queued
// - overflow     : sticky, a non-empty timestep was dropped
// - drop_cnt     : saturating count of dropped non-empty timesteps
module spike_aer_encoder
    import neuron_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_NEURONS-1:0] spikes_in,
    input  logic                 spikes_valid,
    spike_aer_encoder_if.master  aer,
    output logic                 busy,
    output logic                 overflow,
    output logic [DROP_W-1:0]    drop_cnt
);
    logic [TS_W-1:0]      ts_cnt_q, ts_cnt_d;
    logic [TS_W-1:0]      ts_latched_q, ts_latched_d;
    logic [N_NEURONS-1:0] pending_q, pending_d;
    logic                 overflow_q, overflow_d;
    logic [DROP_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic [ADDR_W-1:0]    low_idx;
    logic                 fifo_full, fifo_empty, pop, drain, strobe_hit;
    logic [AER_W-1:0]     fifo_head;

    // Lowest set bit of pending; scanning downward lets the lowest index win.
    always_comb begin
        low_idx = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (pending_q[i]) low_idx = ADDR_W'(i);
        end
    end

    assign pop        = !fifo_empty && aer.aer_ready;
    assign drain      = (pending_q != '0) && (!fifo_full || pop);
    assign strobe_hit = spikes_valid && (spikes_in != '0);

    always_comb begin
        ts_cnt_d     = ts_cnt_q;
        ts_latched_d = ts_latched_q;
        pending_d    = pending_q;
        overflow_d   = overflow_q;
        drop_cnt_d   = drop_cnt_q;

        if (spikes_valid) ts_cnt_d = ts_cnt_q + 1'b1;
        if (drain) pending_d[low_idx] = 1'b0;

        // Capture/drop decide on the registered pending, so a vector arriving
        // while the last bit drains is still dropped.
        if (strobe_hit) begin
            if (pending_q == '0) begin
                pending_d    = spikes_in;
                ts_latched_d = ts_cnt_q;
            end else begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt_q     <= '0;
            ts_latched_q <= '0;
            pending_q    <= '0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            ts_cnt_q     <= ts_cnt_d;
            ts_latched_q <= ts_latched_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    aer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AER_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (drain),
        .push_data (pack_aer(low_idx, ts_latched_q)),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Head fields are forced to zero while empty so stale slots never show.
    assign aer.aer_valid = !fifo_empty;
    assign aer.aer_addr  = fifo_empty ? '0 : fifo_head[AER_W-1:TS_W];
    assign aer.aer_ts    = fifo_empty ? '0 : fifo_head[TS_W-1:0];

    assign busy     = (pending_q != '0) || !fifo_empty;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
